int_to_posit_stream: RTL and testbench

INT_TO_POSIT_STREAM -- requirements
Module: int_to_posit_stream

---
 rtl/int_to_posit_stream.sv | 169 ++++++++++++++++
 tb/tb_int_to_posit_stream.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_posit_stream.sv
// Integer AXI-Stream samples -> posit words, buffered in a FIFO and drained over a req/ack pipe.
// Optional macro ITP_SIGNED_EN: treat samples as two's complement (default build: unsigned).
module int_to_posit_stream #(
    parameter int N     = 8,
    parameter int PS    = 16,
    parameter int ES    = 0,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_axis_tvalid,
    input  logic [N-1:0]  rx_axis_tdata,
    output logic          rx_axis_tready,
    output logic [PS-1:0] pipe_write_data,
    output logic          pipe_write_req,
    input  logic          pipe_write_ack,
    output logic [AW:0]   fifo_level
);
    localparam int TW = ES + N;
    localparam int BW = N + TW + PS + 2;
    localparam int BL = PS - 1;
    localparam int LW = AW + 1;

    logic          s1_valid_q, s1_valid_d;
    logic          s1_sign_q, s1_sign_d;
    logic [N-1:0]  s1_mag_q, s1_mag_d;
    logic [5:0]    s1_scale_q, s1_scale_d;
    logic          s2_valid_q, s2_valid_d;
    logic [PS-1:0] s2_data_q, s2_data_d;
    logic [PS-1:0] mem_q [DEPTH];
    logic [PS-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          tready_q, tready_d;
    logic          req_q, req_d;
    logic [PS-1:0] data_q, data_d;

    logic          accept_s, sign_s;
    logic [N-1:0]  mag_s;
    logic [5:0]    scale_s;
    logic [6:0]    k_s;
    logic [5:0]    e_s;
    logic [N-1:0]  frac_s;
    logic [TW-1:0] tail_s;
    logic [BW-1:0] ones_s, big_s;
    logic [BL-1:0] body_s, round_s;
    logic          guard_s, sticky_s;
    logic [PS-1:0] pos_s;
    logic          push_s, pop_s;

    // Stage 1: accept a sample, split sign/magnitude, find the leading one.
    always_comb begin
        accept_s = rx_axis_tvalid & tready_q;
        sign_s   = 1'b0;
        mag_s    = rx_axis_tdata;
`ifdef ITP_SIGNED_EN
        if (rx_axis_tdata[N-1]) begin
            sign_s = 1'b1;
            mag_s  = -rx_axis_tdata;
        end else begin
            sign_s = 1'b0;
            mag_s  = rx_axis_tdata;
        end
`endif
        scale_s = 6'd0;
        for (int i = 0; i < N; i++) begin
            scale_s = mag_s[i] ? 6'(i) : scale_s;
        end
        s1_valid_d = accept_s;
        if (accept_s) begin
            s1_sign_d  = sign_s;
            s1_mag_d   = mag_s;
            s1_scale_d = scale_s;
        end else begin
            s1_sign_d  = s1_sign_q;
            s1_mag_d   = s1_mag_q;
            s1_scale_d = s1_scale_q;
        end
    end

    // Stage 2: lay out regime ones, terminator, exponent and fraction in a wide field, then round.
    always_comb begin
        k_s      = 7'(s1_scale_q >> ES);
        e_s      = s1_scale_q & 6'((1 << ES) - 1);
        frac_s   = s1_mag_q << (7'(N) - 7'(s1_scale_q));
        tail_s   = TW'({e_s, frac_s});
        ones_s   = ~({BW{1'b1}} >> (k_s + 7'd1));
        big_s    = ones_s | ({tail_s, {(BW-TW){1'b0}}} >> (k_s + 7'd2));
        body_s   = big_s[BW-1 -: BL];
        guard_s  = big_s[BW-PS];
        sticky_s = |big_s[BW-PS-1:0];
        round_s  = BL'(guard_s & (sticky_s | body_s[0]));
        // Regimes that fill the whole body are at or beyond maxpos; clamp there.
        if (s1_mag_q == {N{1'b0}}) begin
            pos_s = {PS{1'b0}};
        end else if (k_s >= 7'(PS - 2)) begin
            pos_s = {1'b0, {BL{1'b1}}};
        end else begin
            pos_s = {1'b0, body_s + round_s};
        end
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            s2_data_d = s1_sign_q ? -pos_s : pos_s;
        end else begin
            s2_data_d = s2_data_q;
        end
    end

    // FIFO bookkeeping, slot reservation for in-flight samples and the registered head word.
    always_comb begin
        push_s   = s2_valid_q;
        pop_s    = req_q & pipe_write_ack;
        wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push_s) - LW'(pop_s);
        mem_d    = mem_q;
        mem_d[wr_ptr_q] = push_s ? s2_data_q : mem_q[wr_ptr_q];
        tready_d = ({1'b0, level_d} + (LW+1)'(s1_valid_d) + (LW+1)'(s2_valid_d)) < (LW+1)'(DEPTH);
        req_d    = (level_d != {LW{1'b0}});
        if (level_d == {LW{1'b0}}) begin
            data_d = data_q;
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            data_d = s2_data_q;
        end else begin
            data_d = mem_q[rd_ptr_d];
        end
    end

    // State registers; reset discards everything in flight or buffered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= {N{1'b0}};
            s1_scale_q <= 6'd0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= {PS{1'b0}};
            mem_q      <= '{default: {PS{1'b0}}};
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            level_q    <= {LW{1'b0}};
            tready_q   <= 1'b0;
            req_q      <= 1'b0;
            data_q     <= {PS{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s1_scale_q <= s1_scale_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tready_q   <= tready_d;
            req_q      <= req_d;
            data_q     <= data_d;
        end
    end

    assign rx_axis_tready  = tready_q;
    assign pipe_write_req  = req_q;
    assign pipe_write_data = data_q;
    assign fifo_level      = level_q;

endmodule

// File: tb/tb_int_to_posit_stream.sv
// Scoreboard bench for int_to_posit_stream: expectations come from a bit-string posit model.
module tb_int_to_posit_stream;
    localparam int N = 8, PS = 16, ES = 0, DEPTH = 8, AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tvalid = 1'b0;
    logic [N-1:0]  tdata = '0;
    logic          tready;
    logic [PS-1:0] wdata;
    logic          req;
    logic          ack = 1'b0;
    logic [AW:0]   level;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [PS-1:0] exp_q[$];
    logic          prev_hold = 1'b0;
    logic [PS-1:0] prev_data = '0;
    logic          rnd_on = 1'b0;

    int_to_posit_stream #(.N(N), .PS(PS), .ES(ES), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .rx_axis_tvalid(tvalid), .rx_axis_tdata(tdata), .rx_axis_tready(tready),
        .pipe_write_data(wdata), .pipe_write_req(req), .pipe_write_ack(ack),
        .fifo_level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    // Reference: write out regime/exponent/fraction as a bit list, keep PS-1 bits, round to nearest even.
    function automatic logic [PS-1:0] model(input logic [N-1:0] d);
        longint v;
        bit neg;
        int s, k, e;
        bit bits[$];
        logic [PS-1:0] body, r;
        bit g, st;
        neg = 1'b0;
        v = longint'(d);
`ifdef ITP_SIGNED_EN
        if (d[N-1]) begin
            neg = 1'b1;
            v = (longint'(1) << N) - v;
        end
`endif
        if (v == 0) return '0;
        s = 0;
        while ((v >> (s + 1)) != 0) s++;
        k = s >> ES;
        e = s % (1 << ES);
        if (k >= PS - 2) begin
            r = {1'b0, {(PS-1){1'b1}}};
        end else begin
            for (int i = 0; i <= k; i++) bits.push_back(1'b1);
            bits.push_back(1'b0);
            for (int i = ES - 1; i >= 0; i--) bits.push_back(bit'((e >> i) & 1));
            for (int i = s - 1; i >= 0; i--) bits.push_back(bit'((v >> i) & 1));
            while (bits.size() < PS + 1) bits.push_back(1'b0);
            body = '0;
            for (int i = 0; i < PS - 1; i++) body = {body[PS-2:0], bits[i]};
            g = bits[PS-1];
            st = 1'b0;
            for (int i = PS; i < bits.size(); i++) st |= bits[i];
            if (g && (st || body[0])) body = body + 1'b1;
            r = body;
        end
        if (neg) r = -r;
        return r;
    endfunction

    function automatic logic [N-1:0] pick();
        logic [N-1:0] x;
        case ($urandom_range(0, 7))
            0: x = '0;
            1: x = '1;
            2: x = N'(1) << (N - 1);
            default: x = N'($urandom);
        endcase
        return x;
    endfunction

    task automatic send(input logic [N-1:0] d, input logic [PS-1:0] e, input int budget, output bit ok);
        tvalid = 1'b1;
        tdata = d;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (tready) begin
                exp_q.push_back(e);
                ok = 1'b1;
            end
        end
        @(posedge clk); #1;
        tvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || level != 0) && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare each popped word with the oldest expectation and check hold stability.
    always @(negedge clk) begin
        if (reset) begin
            if (req && ack) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h, required no word", wdata);
                end else begin
                    check("pop_data", 32'(wdata), 32'(exp_q.pop_front()));
                end
            end
            if (prev_hold && req) check("hold_stable", 32'(wdata), 32'(prev_data));
            prev_hold <= req && !ack;
            prev_data <= wdata;
        end else begin
            prev_hold <= 1'b0;
        end
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        bit ok;
        int lat, acc, run, stale;
        bit started;
        logic [N-1:0] d;
        logic [N-1:0]  dir_in  [5];
        logic [PS-1:0] dir_exp [5];
`ifdef ITP_SIGNED_EN
        dir_in  = '{8'h00, 8'h01, 8'h02, 8'hFF, 8'h40};
        dir_exp = '{16'h0000, 16'h4000, 16'h6000, 16'hC000, 16'h7F00};
`else
        dir_in  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF};
        dir_exp = '{16'h0000, 16'h4000, 16'h6000, 16'h6800, 16'h7FC0};
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready", 32'(tready), 32'd0);
        check("rst_req", 32'(req), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_data", 32'(wdata), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", 32'(tready), 32'd1);
        @(posedge clk); #1;

        // Directed values, one at a time, with acceptance-to-req latency.
        ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(dir_in[i], dir_exp[i], 10, ok);
            check("dir_accept", 32'(ok), 32'd1);
            lat = 0;
            while (lat < 6) begin
                @(negedge clk);
                if (req) break;
                @(posedge clk);
                lat++;
            end
            check("latency", 32'(lat >= 2 && lat <= 3), 32'd1);
            @(posedge clk); #1;
        end

        // Fill with ack held low, then drain back-to-back.
        ack = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            d = pick();
            send(d, model(d), 4, ok);
            acc += int'(ok);
        end
        check("full_accepted", 32'(acc), 32'd8);
        @(negedge clk);
        check("full_tready", 32'(tready), 32'd0);
        check("full_level", 32'(level), 32'(DEPTH));
        @(posedge clk); #1;
        ack = 1'b1;
        run = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req) run++;
        end
        check("b2b_pops", 32'(run), 32'd8);
        @(posedge clk); #1;
        check("level_after_drain", 32'(level), 32'd0);
        for (int i = 0; i < 4; i++) begin
            d = pick();
            send(d, model(d), 10, ok);
            check("refill_accept", 32'(ok), 32'd1);
        end
        drain(100);

        // Simultaneous push and pop at level 4 while pointers wrap.
        ack = 1'b0;
        started = 1'b0;
        for (int i = 0; i < 24; i++) begin
            d = pick();
            send(d, model(d), 4, ok);
            check("wrap_accept", 32'(ok), 32'd1);
            if (started) begin
                check("wrap_level", 32'(level), 32'd4);
            end else if (level == 4) begin
                ack = 1'b1;
                started = 1'b1;
            end
        end
        ack = 1'b1;
        drain(100);

        // Random traffic with random consumer back-pressure.
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    d = pick();
                    send(d, model(d), 80, ok);
                    check("rnd_accept", 32'(ok), 32'd1);
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    ack = 1'($urandom_range(0, 1));
                end
            end
        join
        ack = 1'b1;
        drain(200);

        // Reset with 5 words buffered and 2 in flight.
        ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            d = pick();
            send(d, model(d), 4, ok);
        end
        check("pre_reset_level", 32'(level), 32'd5);
        reset = 1'b0;
        #1;
        check("mid_rst_req", 32'(req), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_tready", 32'(tready), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        ack = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req) stale++;
        end
        check("no_stale", 32'(stale), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            d = pick();
            send(d, model(d), 10, ok);
            check("post_rst_accept", 32'(ok), 32'd1);
        end
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
